// File: rtl/draw_menu_image_if.sv
// Pixel-stream bundle for the main-menu overlay stage: VGA timing in/out,
// the image_rom address/data pair, the show request and the fade status.
interface draw_menu_image_if;
  logic        show;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [19:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        fade_busy;

  // The drawing stage itself sits on this side.
  modport slave (
    input  show, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, rom_rgb,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
           vblnk_out, rgb_out, fade_busy
  );

  modport master (
    output show, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, rom_rgb,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
           vblnk_out, rgb_out, fade_busy
  );
endinterface

// File: rtl/draw_menu_image.sv
// Overlays the main-menu bitmap from image_rom onto the VGA pixel stream with a
// 3-clock pipeline and a frame-counted brightness fade driven by 'show'.
module draw_menu_image #(
  parameter int XPOS             = 0,
  parameter int YPOS             = 0,
  parameter int IMG_W            = 1024,
  parameter int IMG_H            = 768,
  parameter int FADE_STEP_FRAMES = 4
) (
  input logic              clk,
  input logic              rst_n,
  draw_menu_image_if.slave vga
);

  localparam logic [1:0] HIDDEN   = 2'd0;
  localparam logic [1:0] FADE_IN  = 2'd1;
  localparam logic [1:0] SHOWN    = 2'd2;
  localparam logic [1:0] FADE_OUT = 2'd3;

  localparam int          X_HI     = XPOS + IMG_W - 1;
  localparam int          Y_HI     = YPOS + IMG_H - 1;
  localparam logic [19:0] STRIDE   = 20'(IMG_W);
  localparam int          CNT_W    = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

  logic        in_win;
  logic [10:0] row;
  logic [10:0] col;
  logic [19:0] addr_next;

  logic        win1, win2;
  logic [11:0] rgb1, rgb2;
  logic [10:0] hc1, hc2, vc1, vc2;
  logic [3:0]  tim1, tim2;

  logic [1:0]       state, state_nxt;
  logic [4:0]       level, level_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             tick;
  logic             wrap;

  // Channel brightness scale: level 16 is unity gain, level 0 is black.
  function automatic logic [3:0] scale4(input logic [3:0] c, input logic [4:0] lv);
    return 4'(({4'd0, c} * {3'd0, lv}) >> 4);
  endfunction

  always_comb begin
    in_win = (int'(vga.hcount_in) >= XPOS) && (int'(vga.hcount_in) <= X_HI) &&
             (int'(vga.vcount_in) >= YPOS) && (int'(vga.vcount_in) <= Y_HI) &&
             !vga.hblnk_in && !vga.vblnk_in;
    row       = vga.vcount_in - 11'(YPOS);
    col       = vga.hcount_in - 11'(XPOS);
    addr_next = {9'd0, row} * STRIDE + {9'd0, col};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.rom_addr   <= '0;
      win1           <= 1'b0;
      win2           <= 1'b0;
      rgb1           <= '0;
      rgb2           <= '0;
      hc1            <= '0;
      hc2            <= '0;
      vc1            <= '0;
      vc2            <= '0;
      tim1           <= '0;
      tim2           <= '0;
      vga.hcount_out <= '0;
      vga.vcount_out <= '0;
      vga.hsync_out  <= 1'b0;
      vga.vsync_out  <= 1'b0;
      vga.hblnk_out  <= 1'b0;
      vga.vblnk_out  <= 1'b0;
      vga.rgb_out    <= '0;
    end else begin
      vga.rom_addr <= in_win ? addr_next : 20'd0;
      win1 <= in_win;
      rgb1 <= vga.rgb_in;
      hc1  <= vga.hcount_in;
      vc1  <= vga.vcount_in;
      tim1 <= {vga.hsync_in, vga.vsync_in, vga.hblnk_in, vga.vblnk_in};
      // Stage 2 waits out the ROM's registered read so data and timing meet.
      win2 <= win1;
      rgb2 <= rgb1;
      hc2  <= hc1;
      vc2  <= vc1;
      tim2 <= tim1;
      vga.hcount_out <= hc2;
      vga.vcount_out <= vc2;
      {vga.hsync_out, vga.vsync_out, vga.hblnk_out, vga.vblnk_out} <= tim2;
      vga.rgb_out <= (win2 && level != 5'd0)
                     ? {scale4(vga.rom_rgb[11:8], level),
                        scale4(vga.rom_rgb[7:4], level),
                        scale4(vga.rom_rgb[3:0], level)}
                     : rgb2;
    end
  end

  assign tick = (vga.hcount_in == 11'd0) && (vga.vcount_in == 11'd0);
  assign wrap = tick && (frame_cnt == CNT_LAST);

  // A change of 'show' wins over a step in the same cycle; the level guards
  // cover a reversal that lands exactly on an end point.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = frame_cnt;
    case (state)
      HIDDEN: begin
        if (vga.show) begin
          state_nxt = FADE_IN;
          cnt_nxt   = '0;
        end
      end
      FADE_IN: begin
        if (!vga.show) begin
          state_nxt = FADE_OUT;
          cnt_nxt   = '0;
        end else if (level == 5'd16) begin
          state_nxt = SHOWN;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = wrap ? '0 : frame_cnt + 1'b1;
          if (wrap) begin
            level_nxt = level + 5'd1;
            if (level == 5'd15) state_nxt = SHOWN;
          end
        end
      end
      SHOWN: begin
        if (!vga.show) begin
          state_nxt = FADE_OUT;
          cnt_nxt   = '0;
        end
      end
      FADE_OUT: begin
        if (vga.show) begin
          state_nxt = FADE_IN;
          cnt_nxt   = '0;
        end else if (level == 5'd0) begin
          state_nxt = HIDDEN;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = wrap ? '0 : frame_cnt + 1'b1;
          if (wrap) begin
            level_nxt = level - 5'd1;
            if (level == 5'd1) state_nxt = HIDDEN;
          end
        end
      end
      default: begin
        state_nxt = HIDDEN;
        level_nxt = 5'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HIDDEN;
      level         <= 5'd0;
      frame_cnt     <= '0;
      vga.fade_busy <= 1'b0;
    end else begin
      state         <= state_nxt;
      level         <= level_nxt;
      frame_cnt     <= cnt_nxt;
      vga.fade_busy <= (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
    end
  end

endmodule
